// File: rtl/dat_mmu_gen2_if.sv
// dat_mmu_gen2_if -- CPU-side bus bundle for the second-generation DAT MMU.
//
// Signals:
//   address_cpu  [15:0]  CPU logical address
//   r_w_cpu              1 = read, 0 = write
//   data_in      [7:0]   CPU write data
//   data_out     [7:0]   register / DAT read data (0 outside the window)
//   data_oe              high while the CPU reads a register in the window
//   io_sel               address falls in the 8-byte register window
//   address_phys         translated physical address
//   mapped               translation active for this cycle
//
// Modports: master = CPU / bus side, slave = the MMU.
// PAGE_BITS and PHYS_BITS must match the parameters of the attached MMU.
interface dat_mmu_gen2_if #(
  parameter int PAGE_BITS = 3,
  parameter int PHYS_BITS = 8
);
  logic [15:0]                       address_cpu;
  logic                              r_w_cpu;
  logic [7:0]                        data_in;
  logic [7:0]                        data_out;
  logic                              data_oe;
  logic                              io_sel;
  logic [PHYS_BITS+16-PAGE_BITS-1:0] address_phys;
  logic                              mapped;

  modport master (
    output address_cpu, r_w_cpu, data_in,
    input  data_out, data_oe, io_sel, address_phys, mapped
  );

  modport slave (
    input  address_cpu, r_w_cpu, data_in,
    output data_out, data_oe, io_sel, address_phys, mapped
  );
endinterface

// File: rtl/dat_mmu_gen2.sv
// dat_mmu_gen2 -- second-generation DAT MMU for the CoCo memory expansion board.
//
// Translates each 6809 logical page to a physical page through an on-chip DAT
// array of 2^TASK_BITS tasks x 2^PAGE_BITS pages. The DAT is programmed through
// a pointer/data port with optional auto-increment. A task switch can be
// deferred by a programmable number of bus cycles.
//
// Optional feature macro: MMU_VECTOR_TASK0_EN
//   When defined, a read of $FFF0-$FFFF with the MMU enabled forces task 0 at
//   the end of that cycle and saves the previous task in SAVED.
//
// Ports:
//   e        bus clock, one period per CPU bus cycle
//   _reset   synchronous active-low reset
//   bus      dat_mmu_gen2_if.slave (CPU address/data in, translation and
//            register read data out)
//
// Register window at IO_BASE: +0 CTRL, +1 TASK, +2 NEXT, +3 DELAY,
// +4 PTR low, +5 PTR high, +6 DATA, +7 SAVED.
module dat_mmu_gen2 #(
  parameter int          TASK_BITS  = 4,
  parameter int          PAGE_BITS  = 3,
  parameter int          PHYS_BITS  = 8,
  parameter int          DELAY_BITS = 4,
  parameter logic [15:0] IO_BASE    = 16'hFF90
) (
  input  logic                 e,
  input  logic                 _reset,
  dat_mmu_gen2_if.slave        bus
);

  localparam int IW = TASK_BITS + PAGE_BITS;
  localparam int OW = 16 - PAGE_BITS;

  typedef enum logic {S_IDLE = 1'b0, S_COUNT = 1'b1} state_t;

  logic [PHYS_BITS-1:0]  dat_q [2**IW];

  state_t                state_q,  state_d;
  logic                  mmu_en_q, mmu_en_d;
  logic                  autoinc_q, autoinc_d;
  logic [TASK_BITS-1:0]  task_q,   task_d;
  logic [TASK_BITS-1:0]  next_q,   next_d;
  logic [DELAY_BITS-1:0] cnt_q,    cnt_d;
  logic [IW-1:0]         ptr_q,    ptr_d;

  logic [PAGE_BITS-1:0]  page;
  logic [OW-1:0]         offs;
  logic [2:0]            reg_off;
  logic                  io_sel, reg_wr, reg_rd, dat_we, vec_rd;
  logic [15:0]           ptr16;
  logic [7:0]            saved_rd;
  logic [7:0]            rd_data;

  // Wraps to zero after the all-ones index.
  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
    return p + 1'b1;
  endfunction

  assign page    = bus.address_cpu[15:OW];
  assign offs    = bus.address_cpu[OW-1:0];
  assign reg_off = bus.address_cpu[2:0];
  assign io_sel  = (bus.address_cpu[15:3] == IO_BASE[15:3]);
  assign reg_wr  = io_sel && !bus.r_w_cpu;
  assign reg_rd  = io_sel &&  bus.r_w_cpu;
  assign dat_we  = reg_wr && (reg_off == 3'd6) && _reset;
  assign ptr16   = 16'(ptr_q);

`ifdef MMU_VECTOR_TASK0_EN
  logic [TASK_BITS-1:0] saved_q, saved_d;
  logic                 prev_vec_q;

  assign vec_rd   = bus.r_w_cpu && mmu_en_q && (bus.address_cpu[15:4] == 12'hFFF);
  assign saved_rd = 8'(saved_q);

  // Only the first byte of a vector fetch captures the interrupted task;
  // the second byte would otherwise overwrite it with 0.
  always_comb begin
    saved_d = saved_q;
    if (vec_rd && !prev_vec_q) saved_d = task_q;
  end

  always_ff @(posedge e) begin
    if (!_reset) begin
      saved_q    <= '0;
      prev_vec_q <= 1'b0;
    end else begin
      saved_q    <= saved_d;
      prev_vec_q <= vec_rd;
    end
  end
`else
  assign vec_rd   = 1'b0;
  assign saved_rd = 8'h00;
`endif

  // DAT storage is not reset; software programs it before enabling the MMU.
  always_ff @(posedge e) begin
    if (dat_we) dat_q[ptr_q] <= bus.data_in[PHYS_BITS-1:0];
  end

  always_ff @(posedge e) begin
    if (!_reset) begin
      state_q   <= S_IDLE;
      mmu_en_q  <= 1'b0;
      autoinc_q <= 1'b0;
      task_q    <= '0;
      next_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      mmu_en_q  <= mmu_en_d;
      autoinc_q <= autoinc_d;
      task_q    <= task_d;
      next_q    <= next_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mmu_en_d  = mmu_en_q;
    autoinc_d = autoinc_q;
    task_d    = task_q;
    next_d    = next_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;

    if (reg_wr) begin
      case (reg_off)
        3'd0: begin
          mmu_en_d  = bus.data_in[7];
          autoinc_d = bus.data_in[6];
        end
        3'd2:    next_d = bus.data_in[TASK_BITS-1:0];
        3'd4:    ptr_d  = IW'({ptr16[15:8], bus.data_in});
        3'd5:    ptr_d  = IW'({bus.data_in, ptr16[7:0]});
        default: ;
      endcase
    end

    if (io_sel && (reg_off == 3'd6) && autoinc_q) ptr_d = ptr_next(ptr_q);

    // Task source priority: TASK write, vector fetch, DELAY arm, expiry.
    // Expiry loads next_d so a NEXT write on the final edge still counts.
    if (reg_wr && (reg_off == 3'd1)) begin
      task_d  = bus.data_in[TASK_BITS-1:0];
      state_d = S_IDLE;
    end else if (vec_rd) begin
      task_d  = '0;
      state_d = S_IDLE;
    end else if (reg_wr && (reg_off == 3'd3)) begin
      state_d = S_COUNT;
      cnt_d   = bus.data_in[DELAY_BITS-1:0];
    end else if (state_q == S_COUNT) begin
      if (cnt_q == '0) begin
        task_d  = next_d;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (reg_off)
      3'd0: rd_data = {mmu_en_q, autoinc_q, 6'b0};
      3'd1: rd_data = 8'(task_q);
      3'd2: rd_data = 8'(next_q);
      3'd3: rd_data = 8'({(state_q == S_COUNT), cnt_q});
      3'd4: rd_data = ptr16[7:0];
      3'd5: rd_data = ptr16[15:8];
      3'd6: rd_data = 8'(dat_q[ptr_q]);
      3'd7: rd_data = saved_rd;
      default: rd_data = 8'h00;
    endcase
  end

  assign bus.io_sel       = io_sel;
  assign bus.data_oe      = reg_rd;
  assign bus.data_out     = reg_rd ? rd_data : 8'h00;
  assign bus.mapped       = mmu_en_q && (bus.address_cpu[15:8] != 8'hFF);
  assign bus.address_phys = bus.mapped ? {dat_q[{task_q, page}], offs}
                                       : {PHYS_BITS'(page), offs};

endmodule

// File: tb/tb_dat_mmu_gen2.sv
// Testbench for dat_mmu_gen2: directed bus cycles with expectations queued per
// cycle and checked by an independent monitor at the falling edge of e.
module tb_dat_mmu_gen2;
  localparam int          TB  = 4;
  localparam int          PB  = 3;
  localparam int          HB  = 8;
  localparam int          DB  = 4;
  localparam logic [15:0] IOB = 16'hFF90;

`ifdef MMU_VECTOR_TASK0_EN
  localparam bit VEC_ON = 1'b1;
`else
  localparam bit VEC_ON = 1'b0;
`endif

  logic e      = 1'b0;
  logic _reset = 1'b0;

  dat_mmu_gen2_if #(.PAGE_BITS(PB), .PHYS_BITS(HB)) bus ();

  dat_mmu_gen2 #(
    .TASK_BITS(TB), .PAGE_BITS(PB), .PHYS_BITS(HB), .DELAY_BITS(DB), .IO_BASE(IOB)
  ) dut (
    .e      (e),
    ._reset (_reset),
    .bus    (bus)
  );

  always #5 e = ~e;

  int cyc = 0;
  always @(posedge e) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    string       name;
    int          sel;
    logic [31:0] exp;
    logic [31:0] mask;
  } item_t;

  item_t q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  bit    done    = 1'b0;

  // sel: 0 = data_out (data_oe must be 1), 1 = address_phys, 2 = mapped, 3 = data_oe
  always @(negedge e) begin
    item_t       it;
    logic [31:0] act, expv, m;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      it   = q.pop_front();
      expv = it.exp;
      m    = it.mask;
      case (it.sel)
        0: begin
          act  = {23'd0, bus.data_oe, bus.data_out};
          expv = expv | 32'h100;
          m    = m | 32'h100;
        end
        1:       act = 32'(bus.address_phys);
        2:       act = {31'd0, bus.mapped};
        default: act = {31'd0, bus.data_oe};
      endcase
      n_total++;
      if (it.tag == cyc && ((act & m) == (expv & m)))
        n_pass++;
      else
        $display("FAIL %s: got %h, expected %h (cycle %0d, queued %0d)",
                 it.name, act & m, expv & m, cyc, it.tag);
    end
    if (done && q.size() > 0) begin
      n_total++;
      $display("FAIL leftover: got %0d unchecked items, expected 0", q.size());
      q.delete();
    end
  end

  task automatic expect_(input string name, input int sel, input logic [31:0] exp,
                         input logic [31:0] mask = 32'hFFFF_FFFF);
    item_t it;
    it.tag  = cyc;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    it.mask = mask;
    q.push_back(it);
  endtask

  task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
    bus.address_cpu = a;
    bus.r_w_cpu     = rw;
    bus.data_in     = d;
  endtask

  task automatic step();
    @(posedge e);
    #1;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    drive(IOB + 16'(off), 1'b0, d);
    step();
  endtask

  task automatic rd(input string n, input int off, input logic [7:0] x,
                    input logic [7:0] m = 8'hFF);
    drive(IOB + 16'(off), 1'b1, 8'h00);
    expect_(n, 0, {24'd0, x}, {24'd0, m});
    step();
  endtask

  task automatic xl(input string n, input logic [15:0] a, input logic [31:0] p,
                    input bit mp);
    drive(a, 1'b1, 8'h00);
    expect_({n, "_phys"}, 1, p);
    expect_({n, "_map"}, 2, {31'd0, mp});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(16'h1234, 1'b1, 8'h00);
    _reset = 1'b0;
    step();
    step();
    _reset = 1'b1;

    // Reset state
    xl("rst_ident", 16'h1234, 32'h0_1234, 1'b0);
    drive(16'h1234, 1'b1, 8'h00);
    expect_("rst_oe", 3, 32'd0);
    step();
    rd("rst_ctrl", 0, 8'h00);
    rd("rst_task", 1, 8'h00);
    rd("rst_next", 2, 8'h00);
    rd("rst_delay", 3, 8'h00);
    rd("rst_ptrl", 4, 8'h00);
    rd("rst_ptrh", 5, 8'h00);
    rd("rst_saved", 7, 8'h00);

    // Auto-increment programming of task 0
    wr(0, 8'h40);
    for (int i = 0; i < 8; i++) wr(6, 8'h38 + 8'(i));
    rd("ptr_after_wr", 4, 8'h08);
    wr(4, 8'h00);
    for (int i = 0; i < 8; i++) rd($sformatf("dat_rd%0d", i), 6, 8'h38 + 8'(i));
    rd("ptr_after_rd", 4, 8'h08);
    wr(4, 8'h7F);
    wr(5, 8'h00);
    wr(6, 8'hAA);
    rd("ptr_wrap", 4, 8'h00);
    rd("ptrh_wrap", 5, 8'h00);
    wr(4, 8'h7F);
    rd("dat_last", 6, 8'hAA);
    rd("ptr_wrap_rd", 4, 8'h00);

    // Manual pointer: page 2 of tasks 1,2,3,5
    wr(0, 8'h00);
    wr(4, 8'h0A);
    wr(6, 8'h15);
    rd("ptr_noinc", 4, 8'h0A);
    rd("dat_t1p2", 6, 8'h15);
    wr(4, 8'h12); wr(6, 8'h22);
    wr(4, 8'h1A); wr(6, 8'h33);
    wr(4, 8'h2A); wr(6, 8'h55);

    // Translation
    wr(0, 8'h80);
    rd("ctrl_rb", 0, 8'h80);
    xl("xl_t0", 16'h4123, 32'h7_4123, 1'b1);
    wr(1, 8'h01);
    xl("xl_t1", 16'h4123, 32'h2_A123, 1'b1);
    xl("xl_io", 16'hFF22, 32'h0_FF22, 1'b0);

    // Deferred switch: NEXT=3, DELAY=2 in cycle k
    wr(2, 8'h03);
    wr(3, 8'h02);
    rd("dly_pend", 3, 8'h12);
    xl("dly_k2", 16'h4123, 32'h2_A123, 1'b1);
    xl("dly_k3", 16'h4123, 32'h2_A123, 1'b1);
    xl("dly_k4", 16'h4123, 32'h6_6123, 1'b1);
    rd("task_dly", 1, 8'h03);
    rd("dly_idle", 3, 8'h00, 8'h10);

    // TASK write cancels a pending switch
    wr(2, 8'h01);
    wr(3, 8'h05);
    rd("dly5_a", 3, 8'h15);
    rd("dly5_b", 3, 8'h14);
    wr(1, 8'h02);
    xl("xl_t2", 16'h4123, 32'h4_4123, 1'b1);
    rd("cancel_pend", 3, 8'h00, 8'h10);
    for (int i = 0; i < 8; i++) begin
      drive(16'h0000, 1'b1, 8'h00);
      step();
    end
    xl("xl_t2_late", 16'h4123, 32'h4_4123, 1'b1);
    rd("task_t2", 1, 8'h02);

    // Vector fetch
    wr(1, 8'h05);
    drive(16'hFFFE, 1'b1, 8'h00);
    step();
    rd("vec_task", 1, VEC_ON ? 8'h00 : 8'h05);
    rd("vec_saved", 7, VEC_ON ? 8'h05 : 8'h00);
    wr(1, 8'h06);
    drive(16'hFFFE, 1'b1, 8'h00);
    step();
    drive(16'hFFFF, 1'b1, 8'h00);
    step();
    rd("vec2_saved", 7, VEC_ON ? 8'h06 : 8'h00);
    rd("vec2_task", 1, VEC_ON ? 8'h00 : 8'h06);
    wr(2, 8'h03);
    wr(3, 8'h04);
    drive(16'hFFFE, 1'b1, 8'h00);
    step();
    rd("vec_cancel", 3, VEC_ON ? 8'h00 : 8'h10, 8'h10);

    // Reset for one edge mid-COUNT
    wr(1, 8'h01);
    wr(2, 8'h03);
    wr(3, 8'h06);
    drive(16'h0000, 1'b1, 8'h00);
    step();
    _reset = 1'b0;
    step();
    _reset = 1'b1;
    rd("rst2_ctrl", 0, 8'h00);
    rd("rst2_task", 1, 8'h00);
    rd("rst2_next", 2, 8'h00);
    rd("rst2_delay", 3, 8'h00);
    rd("rst2_ptrl", 4, 8'h00);
    rd("rst2_saved", 7, 8'h00);
    xl("rst2_xl", 16'h4123, 32'h0_4123, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(16'h0000, 1'b1, 8'h00);
      step();
    end
    rd("rst2_task_late", 1, 8'h00);
    rd("rst2_dly_late", 3, 8'h00);

    done = 1'b1;
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
